// File: rtl/io_bus_pkg.sv
// Shared I/O bus constants and FSM state type.
// Also used by the I/O decode block and the CPU MMIO logic.
package io_bus_pkg;

  localparam int IO_DATA_W = 16;
  localparam int IO_ADDR_W = 16;
  localparam logic [15:0] IO_BASE_ADDR = 16'hC000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } io_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
// On a tie the master that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       idx,
  output logic       valid
);

  assign valid = |req;

  always_comb begin
    idx = 1'b0;
    unique case (1'b1)
      (&req):          idx = ~last;
      (req == 2'b10):  idx = 1'b1;
      default:         idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the MMIO bus between CPU (m0) and
// the debug/loader master (m1); one transaction in flight.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int ADDR_W = IO_ADDR_W,
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_we,
  output logic              io_re,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              busy,
  output logic              err
);

  io_state_t state;

  logic       last_served;
  logic       own;
  logic       cmd_we;
  logic       cmd_ok;
  logic [1:0] gnt;
  logic [1:0] rv;

  logic              win;
  logic              win_vld;
  logic              sel_we;
  logic              sel_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_in;

  rr_arb2 u_arb (
    .req   ({m1_req, m0_req}),
    .last  (last_served),
    .idx   (win),
    .valid (win_vld)
  );

  assign sel_we    = win ? m1_we    : m0_we;
  assign sel_addr  = win ? m1_addr  : m0_addr;
  assign sel_wdata = win ? m1_wdata : m0_wdata;
  assign sel_ok    = (sel_addr >= IO_BASE);

  // Illegal reads complete with zero data.
  assign rd_in = cmd_ok ? io_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      own         <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_ok      <= 1'b0;
      io_addr     <= '0;
      io_wdata    <= '0;
      gnt         <= '0;
      io_we       <= 1'b0;
      io_re       <= 1'b0;
      err         <= 1'b0;
      rv          <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      gnt   <= '0;
      io_we <= 1'b0;
      io_re <= 1'b0;
      err   <= 1'b0;
      rv    <= '0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            state       <= ACCESS;
            last_served <= win;
            own         <= win;
            cmd_we      <= sel_we;
            cmd_ok      <= sel_ok;
            io_addr     <= sel_addr;
            io_wdata    <= sel_wdata;
            gnt[win]    <= 1'b1;
            io_we       <= sel_we & sel_ok;
            io_re       <= ~sel_we & sel_ok;
            err         <= ~sel_ok;
          end
        end
        ACCESS: begin
          if (cmd_we) begin
            state <= IDLE;
          end else begin
            state   <= RESP;
            rv[own] <= 1'b1;
            if (own) m1_rdata <= rd_in;
            else     m0_rdata <= rd_in;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Reset during RESP drops the response pulse in that same cycle.
  assign m0_rvalid = rv[0] & ~rst;
  assign m1_rvalid = rv[1] & ~rst;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: transaction-level model
// predicts grant order, strobes, read data and round timing.
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [15:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic [15:0] io_addr, io_wdata, io_rdata;
  logic        io_we, io_re, busy, err;

  always #5 clk = ~clk;

  io_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_rdata  (io_rdata),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct {
    int          m;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          ok;
    logic [15:0] rd;
  } exp_t;

  exp_t        sq[$];
  int          total = 0;
  int          bad = 0;
  bit          last_m;
  logic [15:0] mdl_rd[2];
  int          exp_gcyc[2];
  int          exp_len;

  // Peripheral: combinational data derived from the address.
  function automatic logic [15:0] periph(logic [15:0] a);
    logic [15:0] d;
    d = a - 16'hC000;
    d = d * 16'd5;
    return d ^ 16'h02AA;
  endfunction

  assign io_rdata = periph(io_addr);

  task automatic chk1(string n, bit act, bit exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", n, act, exp);
    end
  endtask

  task automatic chk16(string n, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic chki(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  function automatic exp_t mk(int m, cmd_t c);
    exp_t e;
    e.m     = m;
    e.we    = c.we;
    e.addr  = c.addr;
    e.wdata = c.wdata;
    e.ok    = (c.addr >= 16'hC000);
    e.rd    = (e.ok && !c.we) ? periph(c.addr) : 16'h0000;
    return e;
  endfunction

  function automatic int tlen(bit we);
    return we ? 2 : 3;
  endfunction

  function automatic cmd_t mkc(bit we, logic [15:0] a, logic [15:0] d);
    cmd_t c;
    c.we = we;
    c.addr = a;
    c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0)
      c.addr = 16'($urandom_range(0, 32'hBFFF));
    else
      c.addr = 16'($urandom_range(32'hC000, 32'hFFFF));
    c.wdata = 16'($urandom);
    return c;
  endfunction

  // Drive requests and predict the order and timing of the round.
  task automatic issue(bit [1:0] mask, cmd_t c0, cmd_t c1);
    cmd_t cs[2];
    int f, s;
    cs[0] = c0;
    cs[1] = c1;
    if (mask[0]) begin
      m0_req = 1'b1; m0_we = c0.we; m0_addr = c0.addr; m0_wdata = c0.wdata;
    end
    if (mask[1]) begin
      m1_req = 1'b1; m1_we = c1.we; m1_addr = c1.addr; m1_wdata = c1.wdata;
    end
    if (mask == 2'b11) begin
      f = last_m ? 0 : 1;
      s = 1 - f;
      sq.push_back(mk(f, cs[f]));
      sq.push_back(mk(s, cs[s]));
      exp_gcyc[f] = 1;
      exp_gcyc[s] = 1 + tlen(cs[f].we);
      exp_len = tlen(cs[f].we) + tlen(cs[s].we);
      last_m = s[0];
    end else begin
      f = mask[1] ? 1 : 0;
      sq.push_back(mk(f, cs[f]));
      exp_gcyc[f] = 1;
      exp_len = tlen(cs[f].we);
      last_m = f[0];
    end
  endtask

  task automatic wait_round(bit [1:0] mask);
    bit [1:0] got;
    int cyc;
    got = ~mask;
    cyc = 0;
    while (got != 2'b11 || busy) begin
      if (cyc == 40) begin
        total++;
        bad++;
        $display("FAIL round_timeout: got=%b want=11", got);
        m0_req = 1'b0;
        m1_req = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
      if (m0_gnt && !got[0]) begin
        chki("gnt_cycle_m0", cyc, exp_gcyc[0]);
        m0_req = 1'b0;
        got[0] = 1'b1;
      end
      if (m1_gnt && !got[1]) begin
        chki("gnt_cycle_m1", cyc, exp_gcyc[1]);
        m1_req = 1'b0;
        got[1] = 1'b1;
      end
    end
    chki("round_len", cyc, exp_len);
  endtask

  // Monitor: pops expectations on grants, checks responses.
  initial begin : mon
    exp_t        cur;
    exp_t        rvi;
    bit          rv_pend;
    logic [15:0] own_rd;
    logic [15:0] oth_rd;
    rv_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("rst_pulses", m0_gnt | m1_gnt | m0_rvalid | m1_rvalid
             | io_we | io_re | err, 1'b0);
        rv_pend = 1'b0;
      end else begin
        if (rv_pend) begin
          rv_pend = 1'b0;
          own_rd = (rvi.m == 0) ? m0_rdata : m1_rdata;
          oth_rd = (rvi.m == 0) ? m1_rdata : m0_rdata;
          chk1("rvalid_owner", (rvi.m == 0) ? m0_rvalid : m1_rvalid, 1'b1);
          chk1("rvalid_other", (rvi.m == 0) ? m1_rvalid : m0_rvalid, 1'b0);
          chk16("rdata_owner", own_rd, rvi.rd);
          chk16("rdata_other", oth_rd, mdl_rd[1 - rvi.m]);
          mdl_rd[rvi.m] = rvi.rd;
        end else begin
          chk1("no_rvalid", m0_rvalid | m1_rvalid, 1'b0);
        end
        if (m0_gnt | m1_gnt) begin
          if (sq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_gnt: got m0=%0b m1=%0b want none",
                     m0_gnt, m1_gnt);
          end else begin
            cur = sq.pop_front();
            chk1("gnt_m0", m0_gnt, cur.m == 0);
            chk1("gnt_m1", m1_gnt, cur.m == 1);
            chk1("io_we", io_we, cur.we && cur.ok);
            chk1("io_re", io_re, !cur.we && cur.ok);
            chk1("err", err, !cur.ok);
            if (cur.ok) chk16("io_addr", io_addr, cur.addr);
            if (cur.we && cur.ok) chk16("io_wdata", io_wdata, cur.wdata);
            if (!cur.we) begin
              rv_pend = 1'b1;
              rvi = cur;
            end
          end
        end else begin
          chk1("idle_strobes", io_we | io_re | err, 1'b0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    last_m = 1'b1;
    exp_len = 0;

    // Reset with both masters requesting; m0 must win afterwards.
    issue(2'b11, mkc(1'b0, 16'hC002, 16'h0), mkc(1'b0, 16'hC003, 16'h0));
    repeat (2) begin
      @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk16("rst_m0_rdata", m0_rdata, 16'h0000);
      chk16("rst_m1_rdata", m1_rdata, 16'h0000);
    end
    rst = 1'b0;
    wait_round(2'b11);

    issue(2'b01, mkc(1'b1, 16'hC001, 16'h0155), mkc(1'b0, 16'h0, 16'h0));
    wait_round(2'b01);

    issue(2'b10, mkc(1'b0, 16'h0, 16'h0), mkc(1'b0, 16'hC000, 16'h0));
    wait_round(2'b10);

    repeat (2) begin
      issue(2'b11, mkc(1'b0, 16'hC010, 16'h0), mkc(1'b0, 16'hC020, 16'h0));
      wait_round(2'b11);
    end

    issue(2'b01, mkc(1'b0, 16'h0010, 16'h0), mkc(1'b0, 16'h0, 16'h0));
    wait_round(2'b01);

    // Reset during the response cycle of an m1 read.
    issue(2'b10, mkc(1'b0, 16'h0, 16'h0), mkc(1'b0, 16'hC044, 16'h0));
    @(negedge clk);
    chk1("rr_gnt", m1_gnt, 1'b1);
    m1_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk1("rr_no_rvalid", m1_rvalid, 1'b0);
    last_m = 1'b1;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    chk1("rr_busy", busy, 1'b0);
    chk16("rr_m1_rdata", m1_rdata, 16'h0000);
    issue(2'b11, mkc(1'b1, 16'hC100, 16'h1111), mkc(1'b1, 16'hC200, 16'h2222));
    wait_round(2'b11);

    for (int i = 0; i < 60; i++) begin
      bit [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(mask, rand_cmd(), rand_cmd());
      wait_round(mask);
    end

    repeat (3) @(negedge clk);
    chki("queue_empty", sq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
